// File: rtl/porta_pkg.sv
// ---------------------------------------------------------------------------
// porta_pkg
// Shared definitions for the porta input debounce slice.
//   NUM_CH           : number of debounced board inputs (a, b, c, sel)
//   ch_idx_e         : index of each channel inside the packed channel vectors
//   DEBOUNCE_DEFAULT : default number of stable cycles before an output moves
//   cnt_width()      : width of a counter that must hold 0 .. depth-1
// ---------------------------------------------------------------------------
package porta_pkg;

    localparam int NUM_CH           = 4;
    localparam int DEBOUNCE_DEFAULT = 16;

    typedef enum int unsigned {
        CH_A   = 0,
        CH_B   = 1,
        CH_C   = 2,
        CH_SEL = 3
    } ch_idx_e;

    // $clog2(1) is 0, so a depth of one still needs a one-bit counter.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One debounced input: a two-flop synchronizer followed by a stability
// counter.  The output level only follows the synchronized input after it has
// disagreed with the output for DEBOUNCE_CYCLES consecutive edges.
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   raw    : asynchronous switch input
//   level  : registered debounced level
//   update : high during the cycle whose closing edge loads a new level
// ---------------------------------------------------------------------------
module debounce_channel
    import porta_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic update
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;
    logic             differs;
    logic             at_term;

    // The counter only runs while the synchronized input disagrees with the
    // output; reaching the terminal count is the moment the output moves.
    assign differs = (sync_2 != level);
    assign at_term = (cnt == CNT_TERM);
    assign update  = differs && at_term;

    // Synchronizer, stability counter and output register.  Any agreement
    // between sync_2 and level throws away the partial count, which is what
    // rejects glitches and bounces shorter than the debounce window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (!differs) begin
                cnt <= '0;
            end else if (at_term) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/porta_input_debounce.sv
// ---------------------------------------------------------------------------
// porta_input_debounce
// Synchronizes and debounces the four raw board switches feeding porta_and.
//   DEBOUNCE_CYCLES        : stable cycles required before an output changes
//   clk                    : system clock, rising edge
//   rst_n                  : synchronous active-low reset
//   raw_a/raw_b/raw_c/raw_sel : asynchronous switch inputs
//   a/b/c/sel              : debounced levels
//   valid                  : post-reset settling complete, sticky until reset
//   changed                : one-cycle strobe after any debounced output moved
// ---------------------------------------------------------------------------
module porta_input_debounce
    import porta_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_a,
    input  logic raw_b,
    input  logic raw_c,
    input  logic raw_sel,
    output logic a,
    output logic b,
    output logic c,
    output logic sel,
    output logic valid,
    output logic changed
);

    localparam int SETTLE_W = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(DEBOUNCE_CYCLES + 1);

    logic [NUM_CH-1:0]   raw_vec;
    logic [NUM_CH-1:0]   level_vec;
    logic [NUM_CH-1:0]   update_vec;
    logic [SETTLE_W-1:0] settle_cnt;

    assign raw_vec[CH_A]   = raw_a;
    assign raw_vec[CH_B]   = raw_b;
    assign raw_vec[CH_C]   = raw_c;
    assign raw_vec[CH_SEL] = raw_sel;

    assign a   = level_vec[CH_A];
    assign b   = level_vec[CH_B];
    assign c   = level_vec[CH_C];
    assign sel = level_vec[CH_SEL];

    // Every channel runs on its own counter so simultaneous changes settle
    // independently.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (raw_vec[i]),
            .level  (level_vec[i]),
            .update (update_vec[i])
        );
    end

    // Settle counter saturates at DEBOUNCE_CYCLES+1, so valid rises on the
    // following edge: the same edge at which a level held since reset first
    // reaches the outputs.  Because changed is built from the pre-edge valid,
    // that initial power-on transition never raises the strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            valid      <= 1'b0;
            changed    <= 1'b0;
        end else begin
            if (settle_cnt != SETTLE_DONE) begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
            end
            if (settle_cnt == SETTLE_DONE) begin
                valid <= 1'b1;
            end
            changed <= valid & (|update_vec);
        end
    end

endmodule

// File: tb/tb_porta_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_porta_input_debounce
// Directed bench for porta_input_debounce with DEBOUNCE_CYCLES = 4.  Inputs
// change 1 ns after a rising edge, so the next edge is sampling edge 1; the
// outputs are read 1 ns after each edge.
// ---------------------------------------------------------------------------
module tb_porta_input_debounce;

    localparam int D = 4;

    logic clk;
    logic rst_n;
    logic raw_a;
    logic raw_b;
    logic raw_c;
    logic raw_sel;
    logic a;
    logic b;
    logic c;
    logic sel;
    logic valid;
    logic changed;

    int check_count;
    int error_count;

    // Observed outputs packed as {a, b, c, sel, valid, changed}.
    logic [5:0] obs_vec;
    assign obs_vec = {a, b, c, sel, valid, changed};

    porta_input_debounce #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_a   (raw_a),
        .raw_b   (raw_b),
        .raw_c   (raw_c),
        .raw_sel (raw_sel),
        .a       (a),
        .b       (b),
        .c       (c),
        .sel     (sel),
        .valid   (valid),
        .changed (changed)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive reset and the four raw switches in one go ({a, b, c, sel}).
    task automatic applyStimulus(input logic rst_val, input logic [3:0] raw_val);
        rst_n   = rst_val;
        raw_a   = raw_val[3];
        raw_b   = raw_val[2];
        raw_c   = raw_val[1];
        raw_sel = raw_val[0];
    endtask

    // Advance n rising edges, parking 1 ns after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Directed scenarios; expected vectors are {a, b, c, sel, valid, changed}.
    initial begin
        check_count = 0;
        error_count = 0;

        // Reset state, then valid must rise exactly at edge D+2.
        applyStimulus(1'b0, 4'b0000);
        tick(2);
        checkOutput("reset_state", obs_vec, 6'b000000);
        applyStimulus(1'b1, 4'b0000);
        tick(D + 1);
        checkOutput("valid_low_edge5", obs_vec, 6'b000000);
        tick(1);
        checkOutput("valid_high_edge6", obs_vec, 6'b000010);
        tick(20);

        // Clean press on raw_a: a rises at edge 6 with a single changed pulse.
        applyStimulus(1'b1, 4'b1000);
        tick(5);
        checkOutput("press_edge5", obs_vec, 6'b000010);
        tick(1);
        checkOutput("press_edge6", obs_vec, 6'b100011);
        tick(1);
        checkOutput("press_edge7", obs_vec, 6'b100010);
        tick(10);

        // Three-edge pulse on raw_b is one edge short and must vanish.
        applyStimulus(1'b1, 4'b1100);
        tick(3);
        applyStimulus(1'b1, 4'b1000);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput("glitch3_quiet", obs_vec, 6'b100010);
        end

        // Four-edge pulse reaches the terminal count: b high after edges 6..9.
        applyStimulus(1'b1, 4'b1100);
        tick(4);
        applyStimulus(1'b1, 4'b1000);
        tick(1);
        checkOutput("pulse4_edge5", obs_vec, 6'b100010);
        tick(1);
        checkOutput("pulse4_rise", obs_vec, 6'b110011);
        tick(1);
        checkOutput("pulse4_edge7", obs_vec, 6'b110010);
        tick(2);
        checkOutput("pulse4_edge9", obs_vec, 6'b110010);
        tick(1);
        checkOutput("pulse4_fall", obs_vec, 6'b100011);
        tick(1);
        checkOutput("pulse4_edge11", obs_vec, 6'b100010);
        tick(10);

        // Five-edge pulse: rises at edge 6, falls at edge 11.
        applyStimulus(1'b1, 4'b1100);
        tick(5);
        applyStimulus(1'b1, 4'b1000);
        tick(1);
        checkOutput("pulse5_rise", obs_vec, 6'b110011);
        tick(4);
        checkOutput("pulse5_edge10", obs_vec, 6'b110010);
        tick(1);
        checkOutput("pulse5_fall", obs_vec, 6'b100011);
        tick(10);

        // Bounce on raw_c: 1,0,1,0,1 then hold; c rises 5 edges after the
        // final 0->1 sample (edge 5), i.e. at edge 10, with one changed pulse.
        begin
            logic [4:0] bounce;
            bounce = 5'b10101;
            for (int i = 4; i >= 0; i--) begin
                applyStimulus(1'b1, {2'b10, bounce[i], 1'b0});
                tick(1);
                checkOutput("bounce_quiet", obs_vec, 6'b100010);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput("bounce_hold", obs_vec, 6'b100010);
        end
        tick(1);
        checkOutput("bounce_rise", obs_vec, 6'b101011);
        tick(1);
        checkOutput("bounce_after", obs_vec, 6'b101010);
        tick(10);

        // Simultaneous raw_b and raw_sel: both land on edge 6, one pulse.
        applyStimulus(1'b1, 4'b1111);
        tick(5);
        checkOutput("simul_edge5", obs_vec, 6'b101010);
        tick(1);
        checkOutput("simul_edge6", obs_vec, 6'b111111);
        tick(1);
        checkOutput("simul_edge7", obs_vec, 6'b111110);
        tick(10);

        // Reset while a is counting down; raw_a returns high during reset,
        // so a stale count would make a rise before the other channels.
        applyStimulus(1'b1, 4'b0111);
        tick(4);
        checkOutput("midcount_a_still_high", obs_vec, 6'b111110);
        applyStimulus(1'b0, 4'b1111);
        tick(1);
        checkOutput("midreset_cleared", obs_vec, 6'b000000);
        applyStimulus(1'b1, 4'b1111);
        for (int i = 0; i < D + 1; i++) begin
            tick(1);
            checkOutput("midreset_settling", obs_vec, 6'b000000);
        end
        tick(1);
        checkOutput("midreset_edge6", obs_vec, 6'b111110);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput("midreset_no_changed", obs_vec, 6'b111110);
        end

        // Power-on with every raw input high from the start of reset.
        applyStimulus(1'b0, 4'b1111);
        tick(2);
        checkOutput("poweron_reset", obs_vec, 6'b000000);
        applyStimulus(1'b1, 4'b1111);
        for (int i = 0; i < D + 1; i++) begin
            tick(1);
            checkOutput("poweron_settling", obs_vec, 6'b000000);
        end
        tick(1);
        checkOutput("poweron_edge6", obs_vec, 6'b111110);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput("poweron_no_changed", obs_vec, 6'b111110);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
